// File: rtl/lcd_timing_divider.sv
`default_nettype none
// ============================================================================
// Module   : lcd_timing_divider
// Purpose  : Loadable clock-enable prescaler (tick / clk_div) plus one-shot
//            delay timer counted in prescaler ticks.
// Revision : 1.0
// ============================================================================
module lcd_timing_divider #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 3599,
  parameter int DELAY_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   div_load,
  input  logic [WIDTH-1:0]       div_value,
  input  logic                   delay_start,
  input  logic [DELAY_WIDTH-1:0] delay_ticks,
  output logic                   tick,
  output logic                   clk_div,
  output logic                   busy,
  output logic                   delay_done
);

  localparam logic [WIDTH-1:0]       C_DEFAULT_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [DELAY_WIDTH-1:0] C_REM_LAST    = DELAY_WIDTH'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       shadow_q, shadow_d;
  logic [WIDTH-1:0]       div_active_q, div_active_d;
  logic [DELAY_WIDTH-1:0] rem_q, rem_d;
  logic                   tick_q, tick_d;
  logic                   clk_div_q, clk_div_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   run;
  logic                   wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      shadow_q     <= C_DEFAULT_DIV;
      div_active_q <= C_DEFAULT_DIV;
      rem_q        <= '0;
      tick_q       <= 1'b0;
      clk_div_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      div_active_q <= div_active_d;
      rem_q        <= rem_d;
      tick_q       <= tick_d;
      clk_div_q    <= clk_div_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    run  = enable | busy_q;
    // ">=" lets a freshly lowered divisor force a wrap on the next edge
    wrap = run & (cnt_q >= div_active_q);

    // A load coinciding with a wrap is forwarded straight into div_active
    shadow_d     = div_load ? div_value : shadow_q;
    div_active_d = div_active_q;
    if (wrap || !run) begin
      div_active_d = shadow_d;
    end

    cnt_d = cnt_q;
    if (wrap) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + 1'b1;
    end

    tick_d    = wrap;
    clk_div_d = clk_div_q ^ wrap;

    state_d = state_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (delay_start) begin
          if (delay_ticks != '0) begin
            cnt_d   = '0;
            rem_d   = delay_ticks;
            busy_d  = 1'b1;
            state_d = S_WAIT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (wrap) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == C_REM_LAST) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign tick       = tick_q;
  assign clk_div    = clk_div_q;
  assign busy       = busy_q;
  assign delay_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_timing_divider
// Purpose  : Self-checking bench: directed timing sequences, delay table and
//            randomized traffic against a behavioural reference model.
// Revision : 1.0
// ============================================================================
module tb_lcd_timing_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        div_load;
  logic [15:0] div_value;
  logic        delay_start;
  logic [7:0]  delay_ticks;
  logic        tick;
  logic        clk_div;
  logic        busy;
  logic        delay_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  lcd_timing_divider #(
    .WIDTH      (16),
    .DEFAULT_DIV(3599),
    .DELAY_WIDTH(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .div_load   (div_load),
    .div_value  (div_value),
    .delay_start(delay_start),
    .delay_ticks(delay_ticks),
    .tick       (tick),
    .clk_div    (clk_div),
    .busy       (busy),
    .delay_done (delay_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int n;
    int exp_lat;
    int exp_ticks;
  } delay_vec_t;

  // Reference model: wrap positions, remaining-tick count, output levels
  int m_pos, m_limit, m_pending, m_left;
  bit m_tick, m_sq, m_done;

  task automatic check(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_div(input int d);
    div_load  = 1'b1;
    div_value = 16'(d);
    step();
    div_load  = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < 10000);
  endtask

  task automatic run_delay(input int n, input int restart_at, input int restart_n,
                           output int lat, output int tk, output int bad);
    delay_start = 1'b1;
    delay_ticks = 8'(n);
    step();
    delay_start = 1'b0;
    lat = 0; tk = 0; bad = 0;
    while (!delay_done && lat < 5000) begin
      if (!busy) bad++;
      if (lat == restart_at) begin
        delay_start = 1'b1;
        delay_ticks = 8'(restart_n);
      end
      step();
      delay_start = 1'b0;
      lat++;
      if (tick) tk++;
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_limit = 3599; m_pending = 3599; m_left = 0;
    m_tick = 0; m_sq = 0; m_done = 0;
  endtask

  task automatic model_step(input bit rst, input bit en, input bit ld, input int val,
                            input bit st, input int n);
    bit moving, wrapped, fresh;
    if (rst) begin
      model_reset();
      return;
    end
    moving  = en || (m_left > 0);
    wrapped = moving && (m_pos >= m_limit);
    fresh   = 0;
    if (ld) m_pending = val;
    m_tick = wrapped;
    if (wrapped) m_sq = !m_sq;
    m_done = 0;
    if (m_left == 0) begin
      if (st && n == 0) m_done = 1;
      else if (st) begin
        m_left = n;
        fresh  = 1;
      end
    end else if (wrapped) begin
      m_left = m_left - 1;
      m_done = (m_left == 0);
    end
    if (fresh || wrapped) m_pos = 0;
    else if (moving) m_pos = m_pos + 1;
    if (wrapped || !moving) m_limit = m_pending;
  endtask

  initial begin
    delay_vec_t vecs[6];
    int n, t, lat, tk, bad, cnt;
    bit prev;

    vecs[0] = '{d: 9, n: 3, exp_lat: 30, exp_ticks: 3};
    vecs[1] = '{d: 0, n: 1, exp_lat: 1,  exp_ticks: 1};
    vecs[2] = '{d: 0, n: 5, exp_lat: 5,  exp_ticks: 5};
    vecs[3] = '{d: 4, n: 2, exp_lat: 10, exp_ticks: 2};
    vecs[4] = '{d: 2, n: 7, exp_lat: 21, exp_ticks: 7};
    vecs[5] = '{d: 9, n: 0, exp_lat: 0,  exp_ticks: 0};

    reset = 1'b1; enable = 1'b1; div_load = 1'b0; div_value = '0;
    delay_start = 1'b0; delay_ticks = '0;
    repeat (3) step();
    check("reset_outputs", {tick, clk_div, busy, delay_done}, 0);
    reset = 1'b0;

    // Default divisor: 3600-cycle tick spacing, 7200-cycle clk_div period
    wait_tick(n);
    check("first_tick_latency", n, 3600);
    check("clk_div_after_tick1", clk_div, 1);
    wait_tick(n);
    check("default_tick_period", n, 3600);
    check("clk_div_after_tick2", clk_div, 0);

    // Load D=4 mid-period: current period completes first
    repeat (100) step();
    load_div(4);
    wait_tick(n);
    check("period_before_load", n + 101, 3600);
    wait_tick(n);
    check("period_after_load_a", n, 5);
    wait_tick(n);
    check("period_after_load_b", n, 5);

    // Load D=2 exactly on a wrap edge
    repeat (4) step();
    load_div(2);
    check("tick_on_load_wrap", tick, 1);
    wait_tick(n);
    check("period_load_at_wrap_a", n, 3);
    wait_tick(n);
    check("period_load_at_wrap_b", n, 3);

    // D=0: tick held high, clk_div toggles every cycle
    repeat (2) step();
    load_div(0);
    check("tick_on_d0_wrap", tick, 1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      prev = clk_div;
      step();
      if (tick && clk_div != prev) cnt++;
    end
    check("d0_tick_and_toggle", cnt, 6);

    enable = 1'b0;
    step();

    foreach (vecs[i]) begin
      load_div(vecs[i].d);
      step();
      run_delay(vecs[i].n, -1, 0, lat, tk, bad);
      check($sformatf("delay_latency_d%0d_n%0d", vecs[i].d, vecs[i].n), lat, vecs[i].exp_lat);
      check($sformatf("delay_ticks_d%0d_n%0d", vecs[i].d, vecs[i].n), tk, vecs[i].exp_ticks);
      check($sformatf("busy_gap_d%0d_n%0d", vecs[i].d, vecs[i].n), bad, 0);
      check($sformatf("busy_low_at_done_n%0d", vecs[i].n), busy, 0);
      cnt = 0;
      for (int j = 0; j < 4; j++) begin
        step();
        if (tick || delay_done || busy) cnt++;
      end
      check($sformatf("halted_after_n%0d", vecs[i].n), cnt, 0);
    end

    // Second start 5 cycles into a delay must be ignored
    load_div(9);
    step();
    run_delay(3, 4, 7, lat, tk, bad);
    check("restart_ignored_latency", lat, 30);
    check("restart_ignored_ticks", tk, 3);
    check("restart_ignored_busy", bad, 0);

    // Reset 12 cycles into an N=3, D=9 delay aborts it
    delay_start = 1'b1;
    delay_ticks = 8'd3;
    step();
    delay_start = 1'b0;
    repeat (11) step();
    check("busy_before_abort", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_outputs", {tick, clk_div, busy, delay_done}, 0);
    cnt = 0;
    for (int j = 0; j < 60; j++) begin
      step();
      if (delay_done || busy || tick) cnt++;
    end
    check("no_done_after_abort", cnt, 0);
    enable = 1'b1;
    wait_tick(n);
    check("divisor_restored", n, 3600);

    // Randomized traffic against the reference model
    reset = 1'b1;
    step();
    model_step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    reset = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      enable      = $urandom_range(0, 1);
      div_load    = ($urandom_range(0, 9) == 0);
      div_value   = 16'($urandom_range(0, 6));
      delay_start = ($urandom_range(0, 6) == 0);
      delay_ticks = 8'($urandom_range(0, 4));
      step();
      model_step(reset, enable, div_load, int'(div_value), delay_start, int'(delay_ticks));
      t = {28'd0, m_tick, m_sq, (m_left > 0), m_done};
      check($sformatf("random_cycle_%0d", i), {28'd0, tick, clk_div, busy, delay_done}, t);
    end
    reset = 1'b0; div_load = 1'b0; delay_start = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
